// File: rtl/ixc_skid_pkg.sv
// Shared types for the ixc_skid register slice: state encoding doubles as occupancy.
package ixc_skid_pkg;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } sk_state_t;

  localparam int SK_DEPTH = 2;
  localparam int SK_WIDTH = 29;

endpackage

// File: rtl/ixc_skid_entry.sv
// One storage entry of the skid slice: load-enabled register, async active-low clear.
module ixc_skid_entry #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = ld ? d : q_q;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ixc_skid_29.sv
// Two-entry valid/ready skid buffer; in_ready and out_data are registered.
// Optional IXC_SKID_PARITY_EN adds per-entry even parity and a sticky par_err output.
module ixc_skid_29
  import ixc_skid_pkg::*;
#(
  parameter int WIDTH = SK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef IXC_SKID_PARITY_EN
  output logic             par_err,
`endif
  output logic [1:0]       occ
);

`ifdef IXC_SKID_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  sk_state_t     state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          main_ld, skid_ld, main_from_skid;
  logic [EW-1:0] in_word, main_d, main_q, skid_q;
  logic          push, pop;

`ifdef IXC_SKID_PARITY_EN
  assign in_word = {^in_data, in_data};
`else
  assign in_word = in_data;
`endif

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = SK_EMPTY;
    end else begin
      unique case (state_q)
        SK_EMPTY: if (push) begin
          state_d = SK_ONE;
          main_ld = 1'b1;
        end
        SK_ONE: begin
          if (push && !pop) begin
            state_d = SK_TWO;
            skid_ld = 1'b1;
          end else if (push && pop) begin
            main_ld = 1'b1;
          end else if (pop) begin
            state_d = SK_EMPTY;
          end
        end
        SK_TWO: if (pop) begin
          state_d        = SK_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = SK_EMPTY;
      endcase
    end
    in_ready_d = (int'(state_d) < SK_DEPTH);
    main_d     = main_from_skid ? skid_q : in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SK_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  ixc_skid_entry #(.W(EW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  ixc_skid_entry #(.W(EW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (skid_ld),
    .d     (in_word),
    .q     (skid_q)
  );

`ifdef IXC_SKID_PARITY_EN
  logic par_err_q, par_err_d;

  // Sticky: once a presented word disagrees with its stored parity, hold until flush.
  always_comb begin
    par_err_d = flush ? 1'b0
              : (par_err_q | (out_valid & ((^main_q[WIDTH-1:0]) != main_q[WIDTH])));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SK_EMPTY);
  assign out_data  = main_q[WIDTH-1:0];
  assign occ       = state_q;

endmodule

// File: tb/tb_ixc_skid_29.sv
// Self-checking bench for ixc_skid_29 against a queue-based two-slot FIFO model.
// Define IXC_SKID_PARITY_EN to also exercise the parity error path.
module tb_ixc_skid_29;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_data;
  logic [1:0]  occ;
`ifdef IXC_SKID_PARITY_EN
  logic        par_err;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: ordered list of held words and the registered ready flag.
  logic [28:0] mq[$];
  logic        m_ready;

  always #5 clk = ~clk;

  ixc_skid_29 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef IXC_SKID_PARITY_EN
    .par_err   (par_err),
`endif
    .occ       (occ)
  );

  // Apply one cycle of stimulus, advance the model, and return 1ns after the edge.
  task automatic cycle(input logic iv, input logic [28:0] din, input logic ordy,
                       input logic fl, output logic accepted);
    logic push, pop;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    flush     = fl;
    push = iv & m_ready;
    pop  = (mq.size() != 0) & ordy;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(din);
    end
    m_ready  = (mq.size() < 2);
    accepted = push;
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 29'h1234567; out_ready = 1'b0;
    mq.delete(); m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (occ !== 2'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occ); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    vectors++; if (out_data !== 29'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL release_in_ready_pre got %0b want 0", in_ready); end
    cycle(1'b1, 29'h1234567, 1'b0, 1'b0, acc);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    vectors++; if (occ !== 2'd0) begin miscompares++; $display("FAIL release_no_push occ got %0d want 0", occ); end
  endtask

  task automatic test_stream();
    logic acc;
    for (int k = 1; k <= 9; k++) begin
      cycle(k <= 8, 29'(k), 1'b1, 1'b0, acc);
      vectors++; if (occ !== 2'(mq.size())) begin miscompares++; $display("FAIL stream_occ[%0d] got %0d want %0d", k, occ, mq.size()); end
      vectors++; if (out_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL stream_valid[%0d] got %0b want %0b", k, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        vectors++; if (out_data !== mq[0]) begin miscompares++; $display("FAIL stream_data[%0d] got %h want %h", k, out_data, mq[0]); end
      end
      if (k <= 8) begin
        vectors++; if (occ !== 2'd1 || out_data !== 29'(k)) begin miscompares++; $display("FAIL stream_rate[%0d] occ %0d data %h want occ 1 data %h", k, occ, out_data, 29'(k)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    cycle(1'b1, 29'h1ABCDEF, 1'b0, 1'b0, acc);
    cycle(1'b1, 29'h0123456, 1'b0, 1'b0, acc);
    cycle(1'b0, 29'h0,       1'b0, 1'b0, acc);
    vectors++; if (occ !== 2'd2) begin miscompares++; $display("FAIL bp_occ got %0d want 2", occ); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    vectors++; if (out_data !== 29'h1ABCDEF) begin miscompares++; $display("FAIL bp_hold got %h want 1abcdef", out_data); end
    cycle(1'b1, 29'h0BADBAD, 1'b1, 1'b0, acc);
    vectors++; if (acc !== 1'b0) begin miscompares++; $display("FAIL bp_push_blocked model accepted %0b want 0", acc); end
    vectors++; if (out_data !== 29'h0123456 || occ !== 2'd1) begin miscompares++; $display("FAIL bp_second got %h occ %0d want 0123456 occ 1", out_data, occ); end
    cycle(1'b0, 29'h0, 1'b1, 1'b0, acc);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_drain valid %0b ready %0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_flush();
    logic acc;
    cycle(1'b1, 29'h0000AAA, 1'b0, 1'b0, acc);
    cycle(1'b1, 29'h0000BBB, 1'b0, 1'b0, acc);
    cycle(1'b1, 29'h1FFFFFFF, 1'b0, 1'b1, acc);
    vectors++; if (occ !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_state occ %0d valid %0b want 0 0", occ, out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    cycle(1'b1, 29'h1FFFFFFF, 1'b0, 1'b1, acc);
    cycle(1'b0, 29'h0, 1'b1, 1'b0, acc);
    vectors++; if (occ !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop occ %0d valid %0b want 0 0", occ, out_valid); end
  endtask

  task automatic test_async_reset();
    logic acc;
    cycle(1'b1, 29'h0055555, 1'b0, 1'b0, acc);
    cycle(1'b1, 29'h00AAAAA, 1'b0, 1'b0, acc);
    vectors++; if (occ !== 2'd2) begin miscompares++; $display("FAIL arst_pre_occ got %0d want 2", occ); end
    #2 rst_n = 1'b0;
    mq.delete(); m_ready = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b0 || out_data !== 29'h0) begin
      miscompares++; $display("FAIL arst_now valid %0b occ %0d ready %0b data %h want all 0", out_valid, occ, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 29'h0, 1'b1, 1'b0, acc);
    vectors++; if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL arst_after valid %0b occ %0d ready %0b want 0 0 1", out_valid, occ, in_ready);
    end
  endtask

  task automatic test_random();
    logic        acc, iv, pend;
    logic [28:0] d;
    pend = 1'b0;
    d    = '0;
    for (int n = 0; n < 400; n++) begin
      logic fl;
      fl = ($urandom_range(0, 15) == 0);
      if (!pend) begin
        iv = ($urandom_range(0, 3) != 0);
        d  = 29'($urandom());
      end
      cycle(iv, d, ($urandom_range(0, 2) != 0), fl, acc);
      pend = iv & !acc;
      vectors++; if (occ !== 2'(mq.size()) || in_ready !== m_ready) begin
        miscompares++; $display("FAIL rand_ctrl[%0d] occ %0d ready %0b want %0d %0b", n, occ, in_ready, mq.size(), m_ready);
      end
      vectors++; if (out_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rand_valid[%0d] got %0b want %0b", n, out_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        vectors++; if (out_data !== mq[0]) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", n, out_data, mq[0]); end
      end
    end
  endtask

`ifdef IXC_SKID_PARITY_EN
  task automatic test_parity();
    logic        acc;
    logic [29:0] v;
    cycle(1'b0, 29'h0, 1'b1, 1'b1, acc);
    cycle(1'b1, 29'h0F0F0F0, 1'b0, 1'b0, acc);
    vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL par_clean got %0b want 0", par_err); end
    v = dut.u_main.q_q;
    v[28] = ~v[28];
    force dut.u_main.q_q = v;
    cycle(1'b0, 29'h0, 1'b0, 1'b0, acc);
    vectors++; if (par_err !== 1'b1) begin miscompares++; $display("FAIL par_detect got %0b want 1", par_err); end
    release dut.u_main.q_q;
    cycle(1'b0, 29'h0, 1'b0, 1'b1, acc);
    vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL par_flush got %0b want 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef IXC_SKID_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
